// File: rtl/sram_rw_arbiter.sv
// Round-robin arbiter and sequencer for the RW port (port 0) of the OpenRAM 32x256 macro.
// Registers granted commands onto the macro pins and returns read data 3 cycles after grant.
module sram_rw_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,

  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,

  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  // Round-robin pointer: 0 = A granted last, 1 = B granted last.
  logic                  last_q, last_d;

  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  // Read tracking: stage 1 is aligned with the pin register, stage 2 with the macro output phase.
  logic                  s1_vld_q, s1_vld_d;
  logic                  s1_own_q, s1_own_d;
  logic                  s2_vld_q, s2_vld_d;
  logic                  s2_own_q, s2_own_d;

  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

  logic                  a_win, b_win, any_win;
  logic                  sel_we;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;

  always_comb begin
    a_win   = a_req & (~b_req | last_q);
    b_win   = b_req & (~a_req | ~last_q);
    any_win = a_win | b_win;

    a_gnt   = rstn & a_win;
    b_gnt   = rstn & b_win;

    sel_we    = b_win ? b_we    : a_we;
    sel_wmask = b_win ? b_wmask : a_wmask;
    sel_addr  = b_win ? b_addr  : a_addr;
    sel_din   = b_win ? b_din   : a_din;
  end

  always_comb begin
    last_d     = last_q;
    csb_d      = 1'b1;
    web_d      = 1'b1;
    wmask_d    = wmask_q;
    addr_d     = addr_q;
    din_d      = din_q;
    s1_vld_d   = 1'b0;
    s1_own_d   = 1'b0;
    s2_vld_d   = s1_vld_q;
    s2_own_d   = s1_own_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;

    if (any_win) begin
      last_d   = b_win;
      csb_d    = 1'b0;
      web_d    = ~sel_we;
      // Reads drive an all-zero mask so the macro never sees stray byte enables.
      wmask_d  = sel_we ? sel_wmask : '0;
      addr_d   = sel_addr;
      din_d    = sel_din;
      s1_vld_d = ~sel_we;
      s1_own_d = b_win;
    end

    if (s2_vld_q) begin
      if (s2_own_q) begin
        b_rvalid_d = 1'b1;
        b_rdata_d  = sram_dout;
      end else begin
        a_rvalid_d = 1'b1;
        a_rdata_d  = sram_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q     <= 1'b1;
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      wmask_q    <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_own_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_own_q   <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      last_q     <= last_d;
      csb_q      <= csb_d;
      web_q      <= web_d;
      wmask_q    <= wmask_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      s1_vld_q   <= s1_vld_d;
      s1_own_q   <= s1_own_d;
      s2_vld_q   <= s2_vld_d;
      s2_own_q   <= s2_own_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign sram_csb   = csb_q;
  assign sram_web   = web_q;
  assign sram_wmask = wmask_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;

  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter: behavioural SRAM macro, a transaction-level reference model,
// a directed vector table, random traffic and reset corner cases.
module tb_sram_rw_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        a_req, a_we, b_req, b_we;
  logic [3:0]  a_wmask, b_wmask;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_din, b_din;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        sram_csb, sram_web;
  logic [3:0]  sram_wmask;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_rw_arbiter #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .NUM_WMASKS(4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_wmask   (a_wmask),
    .a_addr    (a_addr),
    .a_din     (a_din),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_wmask   (b_wmask),
    .b_addr    (b_addr),
    .b_din     (b_din),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_wmask(sram_wmask),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  // Macro model: inputs registered on posedge, write and read both act on the following negedge.
  logic [31:0] mem [256];
  logic        m_csb, m_web;
  logic [3:0]  m_wm;
  logic [7:0]  m_ad;
  logic [31:0] m_di;

  always @(posedge clk) begin
    m_csb <= sram_csb;
    m_web <= sram_web;
    m_wm  <= sram_wmask;
    m_ad  <= sram_addr;
    m_di  <= sram_din;
  end

  always @(negedge clk) begin
    if (m_csb === 1'b0) begin
      if (!m_web) begin
        for (int b = 0; b < 4; b++) if (m_wm[b]) mem[m_ad][b*8 +: 8] <= m_di[b*8 +: 8];
      end else begin
        sram_dout <= mem[m_ad];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory image updated in grant order, plus a queue of due read responses.
  typedef struct {
    bit          own;
    int          due;
    logic [31:0] data;
  } rd_t;

  rd_t         pq[$];
  logic [31:0] ref_mem [256];
  int          cyc = 0;
  bit          last_m = 1'b1;
  bit          issued_m = 1'b0;
  logic [31:0] ea_rd = '0;
  logic [31:0] eb_rd = '0;
  bit          m_ag, m_bg, m_arv, m_brv;

  task automatic model_cmd(input bit own, input logic we, input logic [3:0] wm,
                           input logic [7:0] ad, input logic [31:0] di);
    rd_t r;
    if (we) begin
      for (int b = 0; b < 4; b++) if (wm[b]) ref_mem[ad][b*8 +: 8] = di[b*8 +: 8];
    end else begin
      r.own  = own;
      r.due  = cyc + 3;
      r.data = ref_mem[ad];
      pq.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      pq.delete();
      last_m   = 1'b1;
      issued_m = 1'b0;
      ea_rd    = '0;
      eb_rd    = '0;
      chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
      chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
      chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
      chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
      chk("rst_csb", {31'd0, sram_csb}, 32'd1);
      chk("rst_a_rdata", a_rdata, 32'd0);
      chk("rst_b_rdata", b_rdata, 32'd0);
    end else begin
      m_ag  = a_req && (!b_req || last_m);
      m_bg  = b_req && (!a_req || !last_m);
      m_arv = 1'b0;
      m_brv = 1'b0;
      if (pq.size() != 0 && pq[0].due == cyc) begin
        if (pq[0].own) begin
          m_brv = 1'b1;
          eb_rd = pq[0].data;
        end else begin
          m_arv = 1'b1;
          ea_rd = pq[0].data;
        end
        void'(pq.pop_front());
      end
      chk("mon_a_gnt", {31'd0, a_gnt}, {31'd0, m_ag});
      chk("mon_b_gnt", {31'd0, b_gnt}, {31'd0, m_bg});
      chk("mon_a_rvalid", {31'd0, a_rvalid}, {31'd0, m_arv});
      chk("mon_b_rvalid", {31'd0, b_rvalid}, {31'd0, m_brv});
      chk("mon_a_rdata", a_rdata, ea_rd);
      chk("mon_b_rdata", b_rdata, eb_rd);
      chk("mon_csb", {31'd0, sram_csb}, {31'd0, !issued_m});
      issued_m = m_ag || m_bg;
      if (m_ag) begin
        last_m = 1'b0;
        model_cmd(1'b0, a_we, a_wmask, a_addr, a_din);
      end else if (m_bg) begin
        last_m = 1'b1;
        model_cmd(1'b1, b_we, b_wmask, b_addr, b_din);
      end
    end
    cyc++;
  end

  typedef struct {
    logic        a_req, a_we;
    logic [3:0]  a_wm;
    logic [7:0]  a_ad;
    logic [31:0] a_di;
    logic        b_req, b_we;
    logic [3:0]  b_wm;
    logic [7:0]  b_ad;
    logic [31:0] b_di;
    logic        e_ag, e_bg, e_arv, e_brv;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t mk(input logic ar, input logic aw, input logic [3:0] am,
                              input logic [7:0] aa, input logic [31:0] ad,
                              input logic br, input logic bw, input logic [3:0] bm,
                              input logic [7:0] ba, input logic [31:0] bd,
                              input logic eag, input logic ebg, input logic earv,
                              input logic ebrv, input logic [31:0] erd);
    vec_t v;
    v.a_req = ar;  v.a_we = aw;  v.a_wm = am;  v.a_ad = aa;  v.a_di = ad;
    v.b_req = br;  v.b_we = bw;  v.b_wm = bm;  v.b_ad = ba;  v.b_di = bd;
    v.e_ag  = eag; v.e_bg = ebg; v.e_arv = earv; v.e_brv = ebrv; v.e_rd = erd;
    return v;
  endfunction

  task automatic drive_a(input logic r, input logic w, input logic [3:0] m,
                         input logic [7:0] ad, input logic [31:0] d);
    a_req = r; a_we = w; a_wmask = m; a_addr = ad; a_din = d;
  endtask

  task automatic drive_b(input logic r, input logic w, input logic [3:0] m,
                         input logic [7:0] ad, input logic [31:0] d);
    b_req = r; b_we = w; b_wmask = m; b_addr = ad; b_din = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vec [15];
  logic prev_gnt;
  bit   ta, tb;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'(i);
      ref_mem[i] = 32'(i);
    end
    sram_dout = '0;
    rstn = 1'b0;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);

    // Row k's read returns at row k+3.
    vec[0]  = mk(1, 0, 4'h0, 8'h01, 0,            1, 0, 0, 8'h02, 0,  1, 0, 0, 0, 0);
    vec[1]  = mk(1, 0, 4'h0, 8'h01, 0,            1, 0, 0, 8'h02, 0,  0, 1, 0, 0, 0);
    vec[2]  = mk(1, 0, 4'h0, 8'h01, 0,            1, 0, 0, 8'h02, 0,  1, 0, 0, 0, 0);
    vec[3]  = mk(1, 0, 4'h0, 8'h01, 0,            1, 0, 0, 8'h02, 0,  0, 1, 1, 0, 32'h1);
    vec[4]  = mk(1, 1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 0, 0, 8'h00, 0,  1, 0, 0, 1, 32'h2);
    vec[5]  = mk(1, 0, 4'h0, 8'h10, 0,            0, 0, 0, 8'h00, 0,  1, 0, 1, 0, 32'h1);
    vec[6]  = mk(1, 1, 4'hF, 8'h20, 32'h11223344, 0, 0, 0, 8'h00, 0,  1, 0, 0, 1, 32'h2);
    vec[7]  = mk(1, 1, 4'h5, 8'h20, 32'hAABBCCDD, 0, 0, 0, 8'h00, 0,  1, 0, 0, 0, 0);
    vec[8]  = mk(1, 0, 4'h0, 8'h20, 0,            0, 0, 0, 8'h00, 0,  1, 0, 1, 0, 32'hDEADBEEF);
    vec[9]  = mk(1, 1, 4'hF, 8'h30, 32'h00000055, 0, 0, 0, 8'h00, 0,  1, 0, 0, 0, 0);
    vec[10] = mk(0, 0, 4'h0, 8'h00, 0,            1, 0, 0, 8'h30, 0,  0, 1, 0, 0, 0);
    vec[11] = mk(0, 0, 4'h0, 8'h00, 0,            0, 0, 0, 8'h00, 0,  0, 0, 1, 0, 32'h11BB33DD);
    vec[12] = mk(0, 0, 4'h0, 8'h00, 0,            0, 0, 0, 8'h00, 0,  0, 0, 0, 0, 0);
    vec[13] = mk(0, 0, 4'h0, 8'h00, 0,            0, 0, 0, 8'h00, 0,  0, 0, 0, 1, 32'h55);
    vec[14] = mk(0, 0, 4'h0, 8'h00, 0,            0, 0, 0, 8'h00, 0,  0, 0, 0, 0, 0);

    repeat (3) next_cycle();
    rstn = 1'b1;

    // Idle after reset: pins stay at reset values, nothing granted or returned.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_csb", {31'd0, sram_csb}, 32'd1);
      chk("idle_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
      chk("idle_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    end
    chk("idle_web", {31'd0, sram_web}, 32'd1);
    chk("idle_wmask", {28'd0, sram_wmask}, 32'd0);
    chk("idle_addr", {24'd0, sram_addr}, 32'd0);
    chk("idle_din", sram_din, 32'd0);
    next_cycle();

    prev_gnt = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive_a(vec[i].a_req, vec[i].a_we, vec[i].a_wm, vec[i].a_ad, vec[i].a_di);
      drive_b(vec[i].b_req, vec[i].b_we, vec[i].b_wm, vec[i].b_ad, vec[i].b_di);
      @(negedge clk);
      chk($sformatf("vec%0d_a_gnt", i), {31'd0, a_gnt}, {31'd0, vec[i].e_ag});
      chk($sformatf("vec%0d_b_gnt", i), {31'd0, b_gnt}, {31'd0, vec[i].e_bg});
      chk($sformatf("vec%0d_a_rvalid", i), {31'd0, a_rvalid}, {31'd0, vec[i].e_arv});
      chk($sformatf("vec%0d_b_rvalid", i), {31'd0, b_rvalid}, {31'd0, vec[i].e_brv});
      if (vec[i].e_arv) chk($sformatf("vec%0d_a_rdata", i), a_rdata, vec[i].e_rd);
      if (vec[i].e_brv) chk($sformatf("vec%0d_b_rdata", i), b_rdata, vec[i].e_rd);
      chk($sformatf("vec%0d_csb", i), {31'd0, sram_csb}, {31'd0, !prev_gnt});
      prev_gnt = vec[i].e_ag | vec[i].e_bg;
      next_cycle();
    end

    // Random traffic: each requester holds its command until granted.
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      ta = a_gnt;
      tb = b_gnt;
      next_cycle();
      if (!a_req || ta)
        drive_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
                8'($urandom_range(0, 15)), $urandom);
      if (!b_req || tb)
        drive_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
                8'($urandom_range(0, 15)), $urandom);
    end
    // Let a held command finish before going idle.
    @(negedge clk);
    next_cycle();
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    repeat (6) next_cycle();

    // Reset with two reads in flight: both must be dropped.
    drive_a(1, 0, 0, 8'h01, 0);
    @(negedge clk);
    chk("inflight_rd1_gnt", {31'd0, a_gnt}, 32'd1);
    next_cycle();
    drive_a(1, 0, 0, 8'h02, 0);
    @(negedge clk);
    chk("inflight_rd2_gnt", {31'd0, a_gnt}, 32'd1);
    next_cycle();
    drive_a(0, 0, 0, 0, 0);
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
      chk("post_rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    end
    next_cycle();
    drive_a(1, 0, 0, 8'h01, 0);
    drive_b(1, 0, 0, 8'h02, 0);
    @(negedge clk);
    chk("post_rst_contend_a", {31'd0, a_gnt}, 32'd1);
    chk("post_rst_contend_b", {31'd0, b_gnt}, 32'd0);
    next_cycle();
    drive_a(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_b_after", {31'd0, b_gnt}, 32'd1);
    next_cycle();
    drive_b(0, 0, 0, 0, 0);
    repeat (6) next_cycle();
    chk("final_queue_drained", 32'(pq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_rw_arbiter.md
# sram_rw_arbiter

Two-requester round-robin arbiter and sequencer for the RW port (port 0) of the 32x256 OpenRAM SRAM macro. It accepts at most one command per cycle, drives the macro's registered-input port from its own registers, and tracks in-flight reads so each requester gets its read data back with a fixed latency. It sits between the core data-bus and Wishbone/DMA paths and the macro's port 0. Port 1 (read-only) is not touched.

## Interface
- ADDR_WIDTH, 8, SRAM word address width
- DATA_WIDTH, 32, SRAM word width
- NUM_WMASKS, 4, byte write-enable count (DATA_WIDTH/8)

- clk  in  1  single clock; also drives the macro's clk0
- rstn  in  1  asynchronous, active-low reset
- a_req / b_req  in  1  requester A/B command valid
- a_we / b_we  in  1  1 = write, 0 = read
- a_wmask / b_wmask  in  NUM_WMASKS  byte enables for writes; ignored for reads
- a_addr / b_addr  in  ADDR_WIDTH  word address
- a_din / b_din  in  DATA_WIDTH  write data
- a_gnt / b_gnt  out  1  combinational; command accepted this cycle
- a_rvalid / b_rvalid  out  1  one-cycle pulse, read data valid
- a_rdata / b_rdata  out  DATA_WIDTH  read data; holds its value between pulses
- sram_csb  out  1  to csb0, active low
- sram_web  out  1  to web0, active low
- sram_wmask  out  NUM_WMASKS  to wmask0
- sram_addr  out  ADDR_WIDTH  to addr0
- sram_din  out  DATA_WIDTH  to din0
- sram_dout  in  DATA_WIDTH  from dout0

## Operation
- Arbitration: round-robin with a 1-bit pointer `last` (0=A, 1=B).
  - Only one requester high: it is granted.
  - Both high: grant B if last=0, else grant A.
  - On every grant, `last` is set to the granted requester.
  - Reset value of `last` is 1, so A wins the first contention.
- A requester holds req, we, wmask, addr and din stable until it sees gnt. Commands are accepted one per cycle with no bubbles.
- Issue register:
  - On a grant, the command is registered onto the sram_* outputs at the next edge: csb=0, web=~we, wmask = wmask if we else 0, plus addr and din.
  - With no grant: csb=1 and web=1. wmask, addr and din hold their last values to limit toggling.
- Read tracking: a 2-stage shift register carries (valid, owner) for each issued read, aligned with the macro's input register and output phase. Writes enter the shift register as invalid.
- Return stage: when stage 2 is valid, sram_dout is captured into the owner's rdata register and that owner's rvalid pulses for one cycle. The other requester's rdata is unchanged.
- Writes produce no response. gnt is the only acknowledgment. A write with wmask=0 still uses a slot and changes no memory.
- Ordering:
  - Each requester's responses return in issue order.
  - A read issued the cycle after a write to the same address returns the new data. The macro writes on the negedge before the read's negedge.
- Reset (rstn low, async): sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0, rvalid=0 for both, rdata=0 for both, shift register cleared, last=1. In-flight reads are dropped; no rvalid appears for them after reset is released. gnt is 0 while rstn is low.

## Timing
- Cycle T: req high and granted; gnt high in T.
- End of T: command appears on the sram_* pins.
- End of T+1: macro registers the command.
- Negedge in T+2: macro drives dout0.
- End of T+2: arbiter captures the data.
- Cycle T+3: rvalid high with rdata. Read latency from gnt to rvalid is 3 cycles.
- Peak throughput is 1 command per cycle. Up to 3 reads can be in flight: pin stage plus 2 tracking stages.
- Both rvalid outputs can never be high in the same cycle.

## Test plan
- Reset then idle → all outputs at reset values. sram_csb=1 for 10 cycles. No gnt or rvalid.
- A writes 0xDEADBEEF to addr 0x10 with wmask=4'b1111, then reads 0x10 → a_gnt in the write and read cycles. a_rvalid exactly 3 cycles after the read gnt with a_rdata=0xDEADBEEF. b_rvalid stays 0.
- Partial write: 0x11223344 to 0x20 with mask 1111, then 0xAABBCCDD with mask 0101, then read → 0x11BB33DD.
- A and B request continuously (reads of addr 1 and 2, preloaded 0x1 and 0x2) → grants alternate A,B,A,B…, A first. rvalid alternates with matching data. The sram_csb pin stays 0 every cycle.
- Back-to-back: A writes 0x55 to 0x30 in T, B reads 0x30 in T+1 → b_rvalid in T+4 with 0x00000055.
- Assert rstn low for 1 cycle while 2 reads are in flight → no rvalid afterwards. First post-reset contention grants A.
